// File: rtl/stereo_demux.sv
// stereo_demux: steers a tagged A/B word stream into per-channel holding
// registers and presents each completed A/B pair under a valid/ready handshake.
// Also counts consumed pairs and keeps a sticky flag for duplicate-channel words.
module stereo_demux #(
    parameter int unsigned REGBITS = 16,
    parameter int unsigned CNTBITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [REGBITS-1:0] in_data_i,
    input  logic               in_sel_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [REGBITS-1:0] a_out_o,
    output logic [REGBITS-1:0] b_out_o,
    output logic               pair_valid_o,
    input  logic               pair_ready_i,
    output logic [CNTBITS-1:0] pair_count_o,
    output logic               err_dup_o,
    input  logic               err_clr_i
);

    typedef enum logic [1:0] {
        StEmpty,
        StHaveA,
        StHaveB,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [REGBITS-1:0] a_q, a_d;
    logic [REGBITS-1:0] b_q, b_d;
    logic               pair_valid_q, pair_valid_d;
    logic [CNTBITS-1:0] count_q, count_d;
    logic               err_q, err_d;

    logic accept;
    logic consume;
    logic dup;

    // Ready everywhere except FULL, where a word can only enter if the pair leaves.
    always_comb begin
        in_ready_o = (state_q != StFull) || pair_ready_i;
    end

    // Next-state, holding registers, counter and error flag.
    always_comb begin
        accept  = in_valid_i && in_ready_o;
        consume = pair_valid_q && pair_ready_i;
        dup     = 1'b0;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        count_d = count_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    if (in_sel_i) begin
                        b_d     = in_data_i;
                        state_d = StHaveB;
                    end else begin
                        a_d     = in_data_i;
                        state_d = StHaveA;
                    end
                end
            end
            StHaveA: begin
                if (accept) begin
                    if (in_sel_i) begin
                        b_d     = in_data_i;
                        state_d = StFull;
                    end else begin
                        // Second A before any B: newest word wins, flag the loss.
                        a_d = in_data_i;
                        dup = 1'b1;
                    end
                end
            end
            StHaveB: begin
                if (accept) begin
                    if (!in_sel_i) begin
                        a_d     = in_data_i;
                        state_d = StFull;
                    end else begin
                        b_d = in_data_i;
                        dup = 1'b1;
                    end
                end
            end
            StFull: begin
                if (consume) begin
                    count_d = count_q + CNTBITS'(1);
                    state_d = StEmpty;
                    // Accept in FULL implies consume, so the next pair starts here.
                    if (accept) begin
                        if (in_sel_i) begin
                            b_d     = in_data_i;
                            state_d = StHaveB;
                        end else begin
                            a_d     = in_data_i;
                            state_d = StHaveA;
                        end
                    end
                end
            end
            default: state_d = StEmpty;
        endcase

        pair_valid_d = (state_d == StFull);

        // Set has priority over clear.
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (dup) begin
            err_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StEmpty;
            a_q          <= '0;
            b_q          <= '0;
            pair_valid_q <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pair_valid_q <= pair_valid_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    assign a_out_o      = a_q;
    assign b_out_o      = b_q;
    assign pair_valid_o = pair_valid_q;
    assign pair_count_o = count_q;
    assign err_dup_o    = err_q;

endmodule

// File: tb/tb_stereo_demux.sv
// Self-checking bench for stereo_demux: directed scenarios plus randomized
// traffic compared against a pair-assembly model kept here.
module tb_stereo_demux;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        pair_valid;
    logic        pair_ready;
    logic [7:0]  pair_count;
    logic        err_dup;
    logic        err_clr;

    int n_vec;
    int n_err;

    // Model: which channels currently hold an unpaired/pending word.
    bit          m_ha, m_hb;
    logic [15:0] m_a, m_b;
    logic [7:0]  m_cnt;
    bit          m_err;

    // in_ready seen before the last edge, and what the model wanted.
    logic rdy_obs;
    logic rdy_exp;

    stereo_demux #(
        .REGBITS(16),
        .CNTBITS(8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_sel_i    (in_sel),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_out_o     (a_out),
        .b_out_o     (b_out),
        .pair_valid_o(pair_valid),
        .pair_ready_i(pair_ready),
        .pair_count_o(pair_count),
        .err_dup_o   (err_dup),
        .err_clr_i   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ha  = 0;
        m_hb  = 0;
        m_a   = '0;
        m_b   = '0;
        m_cnt = '0;
        m_err = 0;
    endtask

    // One clock edge of the pair-assembly rules.
    task automatic model_step(input logic v, input logic s, input logic [15:0] d,
                              input logic pr, input logic clr);
        bit full, acc, cons, dup;
        full = m_ha && m_hb;
        acc  = v && (!full || pr);
        cons = full && pr;
        if (cons) begin
            m_cnt = m_cnt + 8'd1;
            m_ha  = 0;
            m_hb  = 0;
        end
        dup = acc && (s ? m_hb : m_ha);
        if (acc) begin
            if (s) begin
                m_b  = d;
                m_hb = 1;
            end else begin
                m_a  = d;
                m_ha = 1;
            end
        end
        if (clr) m_err = 0;
        if (dup) m_err = 1;
    endtask

    // Drive inputs at the falling edge, capture in_ready, advance one rising edge.
    task automatic cycle(input logic v, input logic s, input logic [15:0] d,
                         input logic pr, input logic clr);
        @(negedge clk);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        pair_ready = pr;
        err_clr    = clr;
        #1;
        rdy_obs = in_ready;
        rdy_exp = !(m_ha && m_hb) || pr;
        @(posedge clk);
        model_step(v, s, d, pr, clr);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 0;
        in_sel     = 0;
        in_data    = '0;
        pair_ready = 0;
        err_clr    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({a_out, b_out, pair_valid, pair_count, err_dup} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%h b=%h pv=%b cnt=%h err=%b want all zero",
                     a_out, b_out, pair_valid, pair_count, err_dup);
        end
        rst_n = 1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_pair();
        do_reset();
        cycle(1, 0, 16'h1111, 1, 0);
        n_vec++;
        if (pair_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_half_pv: got %b want 0", pair_valid);
        end
        cycle(1, 1, 16'h2222, 1, 0);
        n_vec++;
        if ({pair_valid, a_out, b_out, err_dup} !== {1'b1, 16'h1111, 16'h2222, 1'b0}) begin
            n_err++;
            $display("FAIL basic_pair: got pv=%b a=%h b=%h err=%b want 1/1111/2222/0",
                     pair_valid, a_out, b_out, err_dup);
        end
        cycle(0, 0, 16'hDEAD, 1, 0);
        n_vec++;
        if ({pair_valid, pair_count} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL basic_consume: got pv=%b cnt=%0d want 0/1", pair_valid, pair_count);
        end
    endtask

    task automatic test_b_first_stall();
        do_reset();
        cycle(1, 1, 16'h00BB, 0, 0);
        cycle(1, 0, 16'h00AA, 0, 0);
        for (int i = 0; i < 3; i++) begin
            // Valid words offered while stalled must be refused.
            cycle(1, i[0], 16'h5A5A, 0, 0);
            n_vec++;
            if ({rdy_obs, pair_valid, a_out, b_out} !== {1'b0, 1'b1, 16'h00AA, 16'h00BB}) begin
                n_err++;
                $display("FAIL stall_hold: got rdy=%b pv=%b a=%h b=%h want 0/1/00aa/00bb",
                         rdy_obs, pair_valid, a_out, b_out);
            end
        end
        cycle(0, 0, 16'h0, 1, 0);
        n_vec++;
        if ({pair_valid, pair_count} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL stall_consume: got pv=%b cnt=%0d want 0/1", pair_valid, pair_count);
        end
    endtask

    task automatic test_dup();
        do_reset();
        cycle(1, 0, 16'h0001, 0, 0);
        cycle(1, 0, 16'h0002, 0, 0);
        n_vec++;
        if (err_dup !== 1'b1) begin
            n_err++;
            $display("FAIL dup_set: got %b want 1", err_dup);
        end
        cycle(1, 1, 16'h0003, 0, 0);
        n_vec++;
        if ({pair_valid, a_out, b_out, err_dup} !== {1'b1, 16'h0002, 16'h0003, 1'b1}) begin
            n_err++;
            $display("FAIL dup_pair: got pv=%b a=%h b=%h err=%b want 1/0002/0003/1",
                     pair_valid, a_out, b_out, err_dup);
        end
        cycle(0, 0, 16'h0, 1, 1);
        n_vec++;
        if ({err_dup, pair_count} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL dup_clear: got err=%b cnt=%0d want 0/1", err_dup, pair_count);
        end
        cycle(1, 1, 16'h0004, 0, 0);
        cycle(1, 1, 16'h0005, 0, 1);
        n_vec++;
        if ({err_dup, b_out} !== {1'b1, 16'h0005}) begin
            n_err++;
            $display("FAIL dup_set_wins: got err=%b b=%h want 1/0005", err_dup, b_out);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            w = 16'($urandom);
            cycle(1, i[0], w, 1, 0);
            n_vec++;
            if ({rdy_obs, pair_valid, pair_count} !== {1'b1, i[0], m_cnt}) begin
                n_err++;
                $display("FAIL stream_%0d: got rdy=%b pv=%b cnt=%0d want 1/%b/%0d",
                         i, rdy_obs, pair_valid, pair_count, i[0], m_cnt);
            end
        end
        cycle(0, 0, 16'h0, 1, 0);
        n_vec++;
        if ({pair_valid, pair_count} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL stream_wrap: got pv=%b cnt=%0d want 0/0", pair_valid, pair_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1, 0, 16'h1234, 0, 0);
        cycle(1, 1, 16'h5678, 0, 0);
        cycle(1, 0, 16'h0F0F, 1, 0);
        n_vec++;
        if ({rdy_obs, pair_valid, a_out, b_out, pair_count} !==
            {1'b1, 1'b0, 16'h0F0F, 16'h5678, 8'd1}) begin
            n_err++;
            $display("FAIL b2b_consume_accept: got rdy=%b pv=%b a=%h b=%h cnt=%0d want 1/0/0f0f/5678/1",
                     rdy_obs, pair_valid, a_out, b_out, pair_count);
        end
        cycle(1, 1, 16'hF0F0, 0, 0);
        n_vec++;
        if ({pair_valid, a_out, b_out, pair_count} !== {1'b1, 16'h0F0F, 16'hF0F0, 8'd1}) begin
            n_err++;
            $display("FAIL b2b_next_pair: got pv=%b a=%h b=%h cnt=%0d want 1/0f0f/f0f0/1",
                     pair_valid, a_out, b_out, pair_count);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            cycle(1, 0, 16'hA5A5, 0, 0);
            if (k == 1) cycle(1, 1, 16'h5A5A, 0, 0);
            // Assert reset between edges and look before any edge arrives.
            #2;
            idle_inputs();
            rst_n = 0;
            #1;
            n_vec++;
            if ({a_out, b_out, pair_valid, pair_count, err_dup, in_ready} !== {42'd0, 1'b1}) begin
                n_err++;
                $display("FAIL async_reset_%0d: got a=%h b=%h pv=%b cnt=%h err=%b rdy=%b want 0s/rdy 1",
                         k, a_out, b_out, pair_valid, pair_count, err_dup, in_ready);
            end
            @(negedge clk);
            rst_n = 1;
            model_reset();
            cycle(1, 1, 16'h00B1, 1, 0);
            cycle(1, 0, 16'h00A1, 1, 0);
            n_vec++;
            if ({pair_valid, a_out, b_out, pair_count} !== {1'b1, 16'h00A1, 16'h00B1, 8'd0}) begin
                n_err++;
                $display("FAIL async_recover_%0d: got pv=%b a=%h b=%h cnt=%0d want 1/00a1/00b1/0",
                         k, pair_valid, a_out, b_out, pair_count);
            end
        end
    endtask

    task automatic test_random();
        logic v, s, pr, clr;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            s   = 1'($urandom);
            pr  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 9) == 0);
            d   = 16'($urandom);
            cycle(v, s, d, pr, clr);
            n_vec++;
            if (rdy_obs !== rdy_exp || pair_valid !== (m_ha && m_hb) || pair_count !== m_cnt ||
                err_dup !== m_err || ((m_ha && m_hb) && (a_out !== m_a || b_out !== m_b))) begin
                n_err++;
                $display("FAIL random_%0d: got rdy=%b pv=%b cnt=%0d err=%b a=%h b=%h want rdy=%b pv=%b cnt=%0d err=%b a=%h b=%h",
                         i, rdy_obs, pair_valid, pair_count, err_dup, a_out, b_out,
                         rdy_exp, m_ha && m_hb, m_cnt, m_err, m_a, m_b);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_pair();
        test_b_first_stall();
        test_dup();
        test_streaming();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
